piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Transmit end of the team's bit-serial link, whose receive end is a flop-chain deserializer.
- Accepts a parallel word over a valid/ready handshake and emits one framed serial sequence: start bit, data, optional even parity, stop bit.
- Bit timing comes from an external single-cycle enable (`bit_en`), so the same block serves any baud divider.

Parameters:
- DATA_W, 8: data bits per frame; legal range 1..32.
- LSB_FIRST, 1: 1 = bit 0 sent first, 0 = bit DATA_W-1 sent first.
- PARITY_EN, 1: 1 = insert even-parity bit after the data, 0 = no parity bit.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- tx_data  in  DATA_W  word to send; sampled only on accept.
- tx_valid  in  1  word available.
- tx_ready  out  1  block can accept a word.
- bit_en  in  1  one-cycle bit-period tick from the baud divider.
- ser_out  out  1  serial line, registered, idle high.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at end of stop bit.

Behaviour:
- Reset: clk and rst_n as decided (rst_n asynchronous, active-low). On assertion, immediately: state=IDLE, ser_out=1, tx_ready=1, busy=0, done=0, shift register=0, bit counter=0.
- Reset mid-frame aborts the frame: line returns high at once, and no done pulse is issued.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_ready=1, ser_out=1.
  - Accept occurs on a cycle where tx_valid && tx_ready.
  - On accept: latch tx_data into the shift register, compute parity = XOR of tx_data, clear the bit counter, go to START.
  - Next cycle: ser_out=0, busy=1, tx_ready=0.
  - bit_en is ignored in IDLE.
- Outside IDLE, tx_ready=0. tx_valid and tx_data are ignored.
- State advance: transitions out of START/DATA/PARITY/STOP happen only on cycles with bit_en=1. ser_out takes the new bit value on the following cycle.
- Bit durations:
  - The start bit lasts from accept until the first bit_en after accept, plus 1 cycle.
  - Every later bit lasts exactly one bit_en interval.
- START → DATA on bit_en. The first data bit is bit 0 if LSB_FIRST=1, else bit DATA_W-1.
- DATA:
  - On each bit_en, shift to the next bit and increment the counter.
  - After the bit_en that ends bit DATA_W-1 (counter == DATA_W-1), go to PARITY if PARITY_EN=1, else STOP.
- PARITY: ser_out = latched parity (even: total ones over data+parity is even). → STOP on bit_en.
- STOP:
  - ser_out=1.
  - On bit_en: go to IDLE, done=1 for exactly that next cycle, busy=0, tx_ready=1.
- Back-to-back: a word accepted in the first IDLE cycle after STOP starts its start bit with no extra idle bit beyond the stop bit. Minimum frame length is 1 + DATA_W + PARITY_EN + 1 bit periods.
- bit_en on the accept cycle does not advance state. It is consumed by IDLE.
- bit_en held high continuously: one bit per clock is legal and must produce the correct frame.
- tx_data is not required to be stable after accept.

Test Plan:
- Reset, then idle 20 cycles with no tx_valid → ser_out=1, tx_ready=1, busy=0, done never pulses.
- DATA_W=8, LSB_FIRST=1, PARITY_EN=1, bit_en every 4th cycle, send 0xA5 → line bits 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB-first, parity 0, stop), each bit 4 cycles after the start bit; done pulses once; tx_ready low throughout the frame.
- Same configuration, send 0x07, LSB_FIRST=0 → data bits 0,0,0,0,0,1,1,1, parity 1, stop 1.
- PARITY_EN=0, bit_en tied high, two back-to-back words 0xFF then 0x00 → 20 consecutive line bits: 0,1×8,1,0,0×8,1; exactly two done pulses.
- rst_n asserted during data bit 3 of 0x3C → ser_out=1 within the same cycle (async); no done pulse; new word 0x81 accepted after release transmits correctly.
- tx_valid held high while busy, with tx_data changing every cycle → only the word present at the accept cycle is transmitted; the next accept happens in the first IDLE cycle.

Source files
------------

// File: rtl/piso_tx.sv
// Transmit end of the bit-serial link: takes a parallel word over valid/ready and
// shifts out start bit, data, optional even parity and stop bit, paced by bit_en.
module piso_tx #(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 1,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              bit_en,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [2:0]        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_parity;
  logic              r_ser;
  logic              r_done;

  logic              w_next_bit;
  logic [DATA_W-1:0] w_shifted;
  logic              w_last;
  logic              w_accept;

  // The bit about to go on the line always sits at the outgoing end of r_shift.
  assign w_next_bit = (LSB_FIRST != 0) ? r_shift[0] : r_shift[DATA_W-1];
  assign w_shifted  = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
  assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));

  assign tx_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign w_accept = tx_valid && tx_ready;
  assign ser_out  = r_ser;
  assign done     = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_parity <= 1'b0;
      r_ser    <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // bit_en is deliberately ignored here, including on the accept cycle.
          if (w_accept) begin
            r_shift  <= tx_data;
            r_parity <= ^tx_data;
            r_cnt    <= '0;
            r_ser    <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (bit_en) begin
            r_ser   <= w_next_bit;
            r_shift <= w_shifted;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_en) begin
            if (w_last) begin
              if (PARITY_EN != 0) begin
                r_ser   <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_ser   <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_ser   <= w_next_bit;
              r_shift <= w_shifted;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (bit_en) begin
            r_ser   <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_en) begin
            r_ser   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ser   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: three instances (LSB+parity, MSB+parity, LSB no parity)
// share clock and reset; expected line bits are queued at issue and checked by a monitor.
module tb_piso_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] d   [3];
  logic       v   [3];
  logic       be  [3];
  logic       rdy [3];
  logic       ser [3];
  logic       bsy [3];
  logic       dn  [3];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_done [3];
  int got_done [3];
  int mode     [3];  // 0: bit_en off, 1: every 4th cycle, 2: held high

  logic q0[$];
  logic q1[$];
  logic q2[$];

  piso_tx #(.DATA_W(8), .LSB_FIRST(1), .PARITY_EN(1)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(d[0]), .tx_valid(v[0]), .tx_ready(rdy[0]),
    .bit_en(be[0]), .ser_out(ser[0]), .busy(bsy[0]), .done(dn[0]));
  piso_tx #(.DATA_W(8), .LSB_FIRST(0), .PARITY_EN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d[1]), .tx_valid(v[1]), .tx_ready(rdy[1]),
    .bit_en(be[1]), .ser_out(ser[1]), .busy(bsy[1]), .done(dn[1]));
  piso_tx #(.DATA_W(8), .LSB_FIRST(1), .PARITY_EN(0)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d[2]), .tx_valid(v[2]), .tx_ready(rdy[2]),
    .bit_en(be[2]), .ser_out(ser[2]), .busy(bsy[2]), .done(dn[2]));

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic push_bit(input int i, input logic b);
    case (i)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  // Expected line image of one frame, built from the word and the instance's configuration.
  task automatic push_frame(input int i, input logic [7:0] w);
    push_bit(i, 1'b0);
    for (int k = 0; k < 8; k++) push_bit(i, (i == 1) ? w[7-k] : w[k]);
    if (i != 2) push_bit(i, ^w);
    push_bit(i, 1'b1);
  endtask

  task automatic pop_bit(input int i, output logic b, output bit ok);
    ok = 1'b1;
    b  = 1'b0;
    case (i)
      0: if (q0.size() > 0) b = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) b = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) b = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic send(input int i, input logic [7:0] w);
    push_frame(i, w);
    exp_done[i]++;
    @(posedge clk); #1;
    v[i] = 1'b1;
    d[i] = w;
    @(posedge clk); #1;
    v[i] = 1'b0;
    d[i] = ~w;
  endtask

  // bit_en generator
  initial begin
    int cyc;
    cyc = 0;
    for (int i = 0; i < 3; i++) be[i] = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < 3; i++)
        be[i] = (mode[i] == 2) ? 1'b1 : ((mode[i] == 1) ? (cyc % 4 == 0) : 1'b0);
    end
  end

  // Monitor: a line bit is complete on any busy cycle whose bit_en will advance it.
  initial begin
    logic pser [3];
    logic pbsy [3];
    logic pbe  [3];
    logic eb;
    bit   ok;
    for (int i = 0; i < 3; i++) begin pser[i] = 1'b1; pbsy[i] = 1'b0; pbe[i] = 1'b0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (dn[i] === 1'b1) got_done[i]++;
        if (bsy[i] === 1'b1 && be[i] === 1'b1) begin
          pop_bit(i, eb, ok);
          if (!ok) chk("unexpected_bit", i, 32'(ser[i]), 32'hE);
          else     chk("line_bit", i, 32'(ser[i]), 32'(eb));
          chk("ready_while_busy", i, 32'(rdy[i]), 32'd0);
        end
        if (bsy[i] === 1'b1 && pbsy[i] && !pbe[i])
          chk("bit_hold", i, 32'(ser[i]), 32'(pser[i]));
        pser[i] = ser[i];
        pbsy[i] = bsy[i];
        pbe[i]  = be[i];
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] held_word(input int k);
    return 8'(k * 37 + 8'h5B);
  endfunction

  initial begin
    int cnt;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0; d[i] = 8'h00; mode[i] = 0; exp_done[i] = 0; got_done[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk("reset_state", i, 32'({ser[i], rdy[i], bsy[i], dn[i]}), 32'b1100);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle with no traffic.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        chk("idle_state", i, 32'({ser[i], rdy[i], bsy[i], dn[i]}), 32'b1100);
    end

    mode[0] = 1;
    mode[1] = 1;
    mode[2] = 2;
    repeat (4) @(posedge clk);

    send(0, 8'hA5);
    repeat (60) @(posedge clk);
    send(1, 8'h07);
    repeat (60) @(posedge clk);

    // Back-to-back on the no-parity instance with bit_en held high.
    send(2, 8'hFF);
    repeat (9) @(posedge clk);
    send(2, 8'h00);
    repeat (30) @(posedge clk);

    // Async reset during data bit 3, then a clean frame.
    send(0, 8'h3C);
    cnt = 0;
    while (cnt < 4) begin
      @(posedge clk);
      if (be[0]) cnt++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_line", 0, 32'(ser[0]), 32'd1);
    chk("async_reset_busy", 0, 32'(bsy[0]), 32'd0);
    chk("async_reset_ready", 0, 32'(rdy[0]), 32'd1);
    chk("async_reset_done", 0, 32'(dn[0]), 32'd0);
    q0.delete();
    exp_done[0]--;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    send(0, 8'h81);
    repeat (60) @(posedge clk);

    // tx_valid held with changing data; accepts only every 12 cycles.
    mode[0] = 2;
    repeat (4) @(posedge clk);
    #1;
    v[0] = 1'b1;
    for (int k = 0; k < 36; k++) begin
      d[0] = held_word(k);
      if (k % 12 == 0) begin
        push_frame(0, held_word(k));
        exp_done[0]++;
      end
      @(posedge clk); #1;
    end
    v[0] = 1'b0;
    repeat (30) @(posedge clk);

    for (int i = 0; i < 3; i++) begin
      chk("leftover_bits", i, 32'(qsize(i)), 32'd0);
      chk("done_count", i, 32'(got_done[i]), 32'(exp_done[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
